// File: rtl/fc_act_feeder.sv
// fc_act_feeder: ping-pong activation buffer feeding the FC MAC.
// The writer fills one bank element by element and commits it. The committed
// bank is streamed as three descending lane segments, one beat per cycle,
// with first/last framing. The other bank can be filled meanwhile.
module fc_act_feeder #(
   parameter int N_ELEM = 108,
   parameter int LANES  = 3,
   parameter int BEATS  = 36,
   parameter int DW     = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [6:0]    wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          wr_commit,
   output logic          wr_ready,
   output logic          drop_err,
   output logic [DW-1:0] mac_in_1,
   output logic [DW-1:0] mac_in_2,
   output logic [DW-1:0] mac_in_3,
   output logic          mac_vld,
   output logic          mac_first,
   output logic          mac_last
);

   // Width of one lane segment inside a vector
   localparam int SEG = N_ELEM / LANES;

   typedef enum logic {S_IDLE, S_STREAM} state_t;

   logic [DW-1:0] mem [2][N_ELEM];
   logic          wr_bank;
   logic          rd_bank;
   logic [1:0]    bank_full;
   logic [1:0]    bank_full_nxt;
   logic [5:0]    beat;
   logic [5:0]    beat_nxt;
   logic [5:0]    beat_sel;
   state_t        state;
   state_t        state_nxt;
   logic          load;
   logic          release_bank;
   logic          wr_ok;
   logic          commit_ok;
   logic [6:0]    idx1;
   logic [6:0]    idx2;
   logic [6:0]    idx3;

   assign wr_ready  = !bank_full[wr_bank];
   assign wr_ok     = wr_en && wr_ready && (wr_addr < 7'(N_ELEM));
   assign commit_ok = wr_commit && wr_ready;

   // Element indices for the beat being loaded; each lane walks its segment downward
   assign idx1 = 7'(BEATS - 1)           - {1'b0, beat_sel};
   assign idx2 = 7'(SEG + BEATS - 1)     - {1'b0, beat_sel};
   assign idx3 = 7'(2 * SEG + BEATS - 1) - {1'b0, beat_sel};

   // Stream FSM next-state: start on a full read bank, release it after the last beat
   always_comb begin
      state_nxt    = state;
      beat_nxt     = beat;
      beat_sel     = beat;
      load         = 1'b0;
      release_bank = 1'b0;
      case (state)
         S_IDLE: begin
            if (bank_full[rd_bank]) begin
               load      = 1'b1;
               beat_sel  = '0;
               beat_nxt  = 6'd1;
               state_nxt = S_STREAM;
            end
         end
         S_STREAM: begin
            load = 1'b1;
            if (beat == 6'(BEATS - 1)) begin
               release_bank = 1'b1;
               state_nxt    = S_IDLE;
            end else begin
               beat_nxt = beat + 6'd1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Full flags: a commit and a release always target different banks
   always_comb begin
      bank_full_nxt = bank_full;
      if (commit_ok) bank_full_nxt[wr_bank] = 1'b1;
      if (release_bank) bank_full_nxt[rd_bank] = 1'b0;
   end

   // Activation storage; a commit-cycle write lands in the bank being committed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < N_ELEM; i++)
               mem[b][i] <= '0;
      end else if (wr_ok) begin
         mem[wr_bank][wr_addr] <= wr_data;
      end
   end

   // Control state, pointers, sticky error and registered lane outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         beat      <= '0;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         bank_full <= '0;
         drop_err  <= 1'b0;
         mac_vld   <= 1'b0;
         mac_first <= 1'b0;
         mac_last  <= 1'b0;
         mac_in_1  <= '0;
         mac_in_2  <= '0;
         mac_in_3  <= '0;
      end else begin
         state     <= state_nxt;
         beat      <= beat_nxt;
         bank_full <= bank_full_nxt;
         if (commit_ok) wr_bank <= ~wr_bank;
         if (release_bank) rd_bank <= ~rd_bank;
         if ((wr_en || wr_commit) && !wr_ready) drop_err <= 1'b1;
         mac_vld   <= load;
         mac_first <= load && (state == S_IDLE);
         mac_last  <= release_bank;
         if (load) begin
            mac_in_1 <= mem[rd_bank][idx1];
            mac_in_2 <= mem[rd_bank][idx2];
            mac_in_3 <= mem[rd_bank][idx3];
         end
      end
   end

endmodule

// File: tb/tb_fc_act_feeder.sv
// Testbench for fc_act_feeder: schedule-level reference model with randomized
// and directed stimulus. Each committed vector is given a start/end edge.
module tb_fc_act_feeder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [6:0] wr_addr = '0;
   logic [1:0] wr_data = '0;
   logic       wr_commit = 1'b0;
   logic       wr_ready, drop_err, mac_vld, mac_first, mac_last;
   logic [1:0] mac_in_1, mac_in_2, mac_in_3;

   fc_act_feeder dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_commit(wr_commit), .wr_ready(wr_ready), .drop_err(drop_err),
      .mac_in_1(mac_in_1), .mac_in_2(mac_in_2), .mac_in_3(mac_in_3),
      .mac_vld(mac_vld), .mac_first(mac_first), .mac_last(mac_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         st;
      int         en;
      bit [215:0] v;
   } vec_t;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         n;
   int         last_end;
   bit         drop_exp;
   bit [215:0] mbank [2];
   bit         mwb;
   vec_t       sched[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", tag, n, obs, exp);
      end
   endtask

   // Vectors committed but not yet released by their last beat
   function automatic int held();
      int h = 0;
      foreach (sched[i]) if (sched[i].en > n) h++;
      return h;
   endfunction

   task automatic check_out();
      int   b = -1;
      vec_t e;
      while (sched.size() > 0 && sched[0].en < n) void'(sched.pop_front());
      foreach (sched[i])
         if (sched[i].st <= n && n <= sched[i].en) begin
            b = n - sched[i].st;
            e = sched[i];
         end
      chk("mac_vld", mac_vld, b >= 0);
      if (b >= 0) begin
         chk("mac_first", mac_first, b == 0);
         chk("mac_last", mac_last, b == 35);
         chk("lane1", mac_in_1, e.v[2*(35-b) +: 2]);
         chk("lane2", mac_in_2, e.v[2*(71-b) +: 2]);
         chk("lane3", mac_in_3, e.v[2*(107-b) +: 2]);
      end
      chk("wr_ready", wr_ready, held() < 2);
      chk("drop_err", drop_err, drop_exp);
   endtask

   // One clock of stimulus, model update, then output check after the edge
   task automatic drive(input logic en, input int a, input int d, input logic c);
      bit rdy;
      int st;
      rdy       = (held() < 2);
      wr_en     = en;
      wr_addr   = a[6:0];
      wr_data   = d[1:0];
      wr_commit = c;
      if ((en || c) && !rdy) drop_exp = 1'b1;
      if (en && rdy && a < 108) mbank[mwb][2*a +: 2] = d[1:0];
      if (c && rdy) begin
         st = (n + 2 > last_end + 1) ? n + 2 : last_end + 1;
         sched.push_back('{st, st + 35, mbank[mwb]});
         last_end = st + 35;
         mwb = ~mwb;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
      wr_en     = 1'b0;
      wr_commit = 1'b0;
      check_out();
   endtask

   task automatic idle(input int k);
      repeat (k) drive(1'b0, 0, 0, 1'b0);
   endtask

   // Asynchronous reset applied away from the clock edge; outputs must clear at once
   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_vld", mac_vld, 0);
      chk("rst_first", mac_first, 0);
      chk("rst_last", mac_last, 0);
      chk("rst_ready", wr_ready, 1);
      chk("rst_drop", drop_err, 0);
      chk("rst_lanes", {mac_in_1, mac_in_2, mac_in_3}, 0);
      sched.delete();
      mbank[0] = '0;
      mbank[1] = '0;
      mwb      = 1'b0;
      drop_exp = 1'b0;
      last_end = -100;
      n        = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      do_reset();

      // Ramp pattern i mod 4, framing and first-beat latency
      for (int i = 0; i < 108; i++) drive(1'b1, i, i % 4, 1'b0);
      drive(1'b0, 0, 0, 1'b1);
      idle(1);
      chk("b0_first", mac_first, 1);
      chk("b0_lanes", {mac_in_1, mac_in_2, mac_in_3}, {2'd3, 2'd3, 2'd3});
      idle(1);
      chk("b1_lanes", {mac_in_1, mac_in_2, mac_in_3}, {2'd2, 2'd2, 2'd2});
      idle(40);

      // Second bank committed while the first streams: contiguous 72 beats
      repeat (10) drive(1'b1, $urandom_range(0, 107), $urandom_range(0, 3), 1'b0);
      drive(1'b0, 0, 0, 1'b1);
      repeat (15) drive(1'b1, $urandom_range(0, 107), $urandom_range(0, 3), 1'b0);
      drive(1'b0, 0, 0, 1'b1);
      idle(80);

      // Commit landing on the same edge that loads the last beat
      repeat (5) drive(1'b1, $urandom_range(0, 107), $urandom_range(0, 3), 1'b0);
      drive(1'b0, 0, 0, 1'b1);
      while (n + 1 < last_end)
         drive(1'b1, $urandom_range(0, 107), $urandom_range(0, 3), 1'b0);
      drive(1'b0, 0, 0, 1'b1);
      idle(80);

      // Out-of-range addresses are ignored without error
      drive(1'b1, 108, 3, 1'b0);
      drive(1'b1, 127, 2, 1'b0);
      drive(1'b0, 0, 0, 1'b1);
      idle(40);
      chk("drop_clean", drop_err, 0);

      // Both banks full: commit and write are dropped and flagged
      drive(1'b0, 0, 0, 1'b1);
      drive(1'b0, 0, 0, 1'b1);
      drive(1'b0, 0, 0, 1'b1);
      drive(1'b1, 5, 1, 1'b0);
      idle(80);
      chk("drop_sticky", drop_err, 1);

      // Reset at beat 20, then a fresh vector
      drive(1'b0, 0, 0, 1'b1);
      while (n < last_end - 15) drive(1'b0, 0, 0, 1'b0);
      do_reset();
      repeat (30) drive(1'b1, $urandom_range(0, 107), $urandom_range(0, 3), 1'b0);
      drive(1'b0, 0, 0, 1'b1);
      idle(40);

      // Random traffic
      repeat (3000)
         drive($urandom_range(0, 1) == 1, $urandom_range(0, 127), $urandom_range(0, 3),
               $urandom_range(0, 29) == 0);
      idle(80);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
